turn_display_controller: RTL and testbench
==========================================

Name: turn_display_controller

Overview:
Game-level sequencer that drives the 4-bit symbol codes into the tic-tac-toe symbol-to-segment decoders.
- Tracks whose turn it is during play and shows it on the turn digit.
- On game end, blinks a "Win" message (with the winner's symbol) or a draw pattern across three message digits for a fixed number of blinks, then returns to idle.
- Sits between the game-logic/win-checker and four instances of the symbol decoder.

Parameters:
BLINK_CYCLES, 25000000, clock cycles per blink phase (on or off); 0.5 s at 50 MHz; must be >= 2.
MSG_BLINKS, 3, number of complete on+off blink pairs shown in WIN/DRAW before returning to IDLE; must be >= 1.
FIRST_PLAYER, 0, player who moves first after start (0 = O, 1 = X).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse; begin or restart a game.
move_valid  input  1  single-cycle pulse; current player made a legal move.
game_win  input  1  single-cycle pulse; the move just made won (winner = current player).
game_draw  input  1  single-cycle pulse; board full, no winner.
digit_turn  output  4  symbol code for turn digit.
digit_msg2  output  4  symbol code, leftmost message digit.
digit_msg1  output  4  symbol code, middle message digit.
digit_msg0  output  4  symbol code, rightmost message digit.
current_player  output  1  0 = O, 1 = X.
game_active  output  1  high only in PLAY.

Behaviour:
- Symbol codes: 0 = O, 1 = X, 2 = underscore, 3 = blank, 4 = W, 5 = i, 6 = n. Codes 7–15 are never driven.
- All outputs are registered; the response to an input pulse is visible one cycle after the pulse edge.
- Reset state (overrides everything):
  - State IDLE; current_player = FIRST_PLAYER; winner register = 0.
  - digit_turn = 2; all msg digits = 3; game_active = 0.
  - Blink counter = 0; blink phase = ON.
- States: IDLE, PLAY, WIN, DRAW.
- Input priority each cycle: start > game_win > game_draw > move_valid.
- IDLE:
  - Outputs: turn = 2, msg = 3/3/3.
  - start -> PLAY with current_player = FIRST_PLAYER. All other inputs are ignored.
- PLAY:
  - Outputs: digit_turn = current_player code; msg = 3/3/3; game_active = 1.
  - move_valid alone -> toggle current_player.
  - game_win -> latch winner = current_player (pre-toggle), go to WIN. No toggle, even if move_valid is coincident.
  - game_draw -> go to DRAW, no toggle.
  - start -> restart: stay in PLAY, current_player = FIRST_PLAYER.
- Entry to WIN or DRAW: clear blink counter to 0, set phase ON, clear pair counter to 0.
- Blink timing:
  - Counter runs 0..BLINK_CYCLES-1. At wrap, the phase toggles.
  - An OFF->ON toggle increments the pair counter.
  - When the pair counter reaches MSG_BLINKS at that toggle, go to IDLE instead of showing ON.
  - Total dwell = 2*MSG_BLINKS*BLINK_CYCLES cycles.
- WIN outputs:
  - Phase ON: msg = 4/5/6, digit_turn = winner code.
  - Phase OFF: all four digits = 3.
- DRAW outputs:
  - Phase ON: msg = 2/2/2, digit_turn = 3.
  - Phase OFF: all = 3.
- In WIN/DRAW:
  - move_valid, game_win and game_draw are ignored.
  - start -> PLAY immediately, with current_player = FIRST_PLAYER and the blink logic cleared.
- Exit to IDLE: current_player is held (not reset) until the next start.
- Reset asserted mid-game or mid-blink returns to the reset state on the next edge, with no partial blink completion.

Decomposition:
- Shared package / include: symbol code constants (SYM_O, SYM_X, SYM_UNDER, SYM_BLANK, SYM_W, SYM_I, SYM_N) and state encoding (2-bit IDLE/PLAY/WIN/DRAW). Both are shared with the decoder and the game logic.
- Sub-module blink_timer:
  - Parameterized cycle counter with a synchronous clear.
  - Phase output plus a one-cycle pulse at each OFF->ON toggle.
  - Pair counting remains in the parent.

Test Plan:
1. Use BLINK_CYCLES=4, MSG_BLINKS=2. Reset, then check: turn=2, msg=3/3/3, game_active=0, current_player=0.
2. start, then 3x move_valid -> player sequence 0,1,0,1; digit_turn follows 0,1,0,1 one cycle after each pulse; game_active=1.
3. With player=1, assert game_win and move_valid in the same cycle -> WIN; no toggle; ON: turn=1, msg=4/5/6 for 4 cycles; OFF: all 3 for 4 cycles; second pair; IDLE after exactly 16 cycles.
4. game_draw in PLAY -> msg=2/2/2 and turn=3 for 4 cycles, then blank for 4, repeat, then IDLE at cycle 16; move_valid during DRAW has no effect.
5. start during WIN OFF phase -> next cycle PLAY, player=0, msg=3/3/3. Then game_win -> blink restarts from a full ON phase of 4 cycles.
6. Assert reset during WIN ON phase and during PLAY with player=1 -> next cycle full reset values; a subsequent start yields player=0.

Source files
------------

// File: rtl/turn_display_controller_pkg.sv
// Shared symbol codes and game-state encoding used by the turn/message sequencer,
// the symbol decoders and the game logic.
package turn_display_controller_pkg;
    localparam logic [3:0] SYM_O     = 4'd0;
    localparam logic [3:0] SYM_X     = 4'd1;
    localparam logic [3:0] SYM_UNDER = 4'd2;
    localparam logic [3:0] SYM_BLANK = 4'd3;
    localparam logic [3:0] SYM_W     = 4'd4;
    localparam logic [3:0] SYM_I     = 4'd5;
    localparam logic [3:0] SYM_N     = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_DRAW = 2'd3
    } gameState_t;

    function automatic logic [3:0] playerSym(input logic player);
        return player ? SYM_X : SYM_O;
    endfunction
endpackage

// File: rtl/turn_display_controller_blink_timer.sv
// Blink phase generator: counts BLINK_CYCLES per phase, flags the wrap and the OFF->ON edge.
module turn_display_controller_blink_timer #(
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic phaseOn,
    output logic wrap,
    output logic offToOn
);
    localparam int CW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

    logic [CW-1:0] cnt;

    // wrap/offToOn are combinational so the parent can act on the same edge the phase flips
    assign wrap    = enable && !clear && (cnt == CW'(BLINK_CYCLES - 1));
    assign offToOn = wrap && !phaseOn;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt     <= '0;
            phaseOn <= 1'b1;
        end else if (enable) begin
            if (wrap) begin
                cnt     <= '0;
                phaseOn <= ~phaseOn;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/turn_display_controller.sv
// Game-level sequencer: shows whose turn it is during play, then blinks a Win or
// draw message for MSG_BLINKS on/off pairs before falling back to idle.
module turn_display_controller
    import turn_display_controller_pkg::*;
#(
    parameter int   BLINK_CYCLES = 25000000,
    parameter int   MSG_BLINKS   = 3,
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       move_valid,
    input  logic       game_win,
    input  logic       game_draw,
    output logic [3:0] digit_turn,
    output logic [3:0] digit_msg2,
    output logic [3:0] digit_msg1,
    output logic [3:0] digit_msg0,
    output logic       current_player,
    output logic       game_active
);
    localparam int PW = $clog2(MSG_BLINKS + 1);

    gameState_t    state, stateN;
    logic          winner, winnerN, playerN;
    logic [PW-1:0] pairCnt, pairN;
    logic          clearBlink, blinkEn, phaseOn, wrap, offToOn, phaseN;
    logic [3:0]    turnN, msg2N, msg1N, msg0N;
    logic          activeN;

    assign blinkEn = (state == ST_WIN) || (state == ST_DRAW);

    turn_display_controller_blink_timer #(.BLINK_CYCLES(BLINK_CYCLES)) uBlink (
        .clk     (clk),
        .reset   (reset),
        .clear   (clearBlink),
        .enable  (blinkEn),
        .phaseOn (phaseOn),
        .wrap    (wrap),
        .offToOn (offToOn)
    );

    always_comb begin
        stateN     = state;
        playerN    = current_player;
        winnerN    = winner;
        pairN      = pairCnt;
        clearBlink = 1'b0;
        if (start) begin
            stateN     = ST_PLAY;
            playerN    = FIRST_PLAYER;
            pairN      = '0;
            clearBlink = 1'b1;
        end else begin
            case (state)
                ST_PLAY: begin
                    if (game_win) begin
                        winnerN    = current_player;
                        stateN     = ST_WIN;
                        pairN      = '0;
                        clearBlink = 1'b1;
                    end else if (game_draw) begin
                        stateN     = ST_DRAW;
                        pairN      = '0;
                        clearBlink = 1'b1;
                    end else if (move_valid) begin
                        playerN = ~current_player;
                    end
                end
                ST_WIN, ST_DRAW: begin
                    if (offToOn) begin
                        pairN = pairCnt + 1'b1;
                        if (pairN == PW'(MSG_BLINKS)) stateN = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end

        // Mirror the timer's next phase so the digits can be registered in step with it
        phaseN = clearBlink ? 1'b1 : (wrap ? ~phaseOn : phaseOn);

        turnN   = SYM_BLANK;
        msg2N   = SYM_BLANK;
        msg1N   = SYM_BLANK;
        msg0N   = SYM_BLANK;
        activeN = 1'b0;
        case (stateN)
            ST_IDLE: turnN = SYM_UNDER;
            ST_PLAY: begin
                turnN   = playerSym(playerN);
                activeN = 1'b1;
            end
            ST_WIN: if (phaseN) begin
                turnN = playerSym(winnerN);
                msg2N = SYM_W;
                msg1N = SYM_I;
                msg0N = SYM_N;
            end
            ST_DRAW: if (phaseN) begin
                msg2N = SYM_UNDER;
                msg1N = SYM_UNDER;
                msg0N = SYM_UNDER;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            current_player <= FIRST_PLAYER;
            winner         <= 1'b0;
            pairCnt        <= '0;
            digit_turn     <= SYM_UNDER;
            digit_msg2     <= SYM_BLANK;
            digit_msg1     <= SYM_BLANK;
            digit_msg0     <= SYM_BLANK;
            game_active    <= 1'b0;
        end else begin
            state          <= stateN;
            current_player <= playerN;
            winner         <= winnerN;
            pairCnt        <= pairN;
            digit_turn     <= turnN;
            digit_msg2     <= msg2N;
            digit_msg1     <= msg1N;
            digit_msg0     <= msg0N;
            game_active    <= activeN;
        end
    end
endmodule

// File: tb/tb_turn_display_controller.sv
// Directed bench for turn_display_controller with BLINK_CYCLES=4, MSG_BLINKS=2.
module tb_turn_display_controller;
    logic       clk = 1'b0;
    logic       reset, start, move_valid, game_win, game_draw;
    logic [3:0] digit_turn, digit_msg2, digit_msg1, digit_msg0;
    logic       current_player, game_active;
    int         compared = 0;
    int         mismatched = 0;

    turn_display_controller #(.BLINK_CYCLES(4), .MSG_BLINKS(2), .FIRST_PLAYER(1'b0)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .move_valid     (move_valid),
        .game_win       (game_win),
        .game_draw      (game_draw),
        .digit_turn     (digit_turn),
        .digit_msg2     (digit_msg2),
        .digit_msg1     (digit_msg1),
        .digit_msg0     (digit_msg0),
        .current_player (current_player),
        .game_active    (game_active)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed as {turn, msg2, msg1, msg0, player, active}
    task automatic check(input string tag, input logic [3:0] t, input logic [3:0] m2,
                         input logic [3:0] m1, input logic [3:0] m0, input logic p, input logic a);
        logic [17:0] obs, exp;
        obs = {digit_turn, digit_msg2, digit_msg1, digit_msg0, current_player, game_active};
        exp = {t, m2, m1, m0, p, a};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; move_valid = 1'b0; game_win = 1'b0; game_draw = 1'b0;
        step(); step();
        reset = 1'b0;
        check("reset", 4'd2, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0);

        // IDLE ignores everything but start
        move_valid = 1'b1; game_win = 1'b1; game_draw = 1'b1;
        step();
        move_valid = 1'b0; game_win = 1'b0; game_draw = 1'b0;
        check("idle_ignore", 4'd2, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0);

        // Start and three moves
        start = 1'b1; step(); start = 1'b0;
        check("play_p0", 4'd0, 4'd3, 4'd3, 4'd3, 1'b0, 1'b1);
        move_valid = 1'b1; step(); move_valid = 1'b0;
        check("move1", 4'd1, 4'd3, 4'd3, 4'd3, 1'b1, 1'b1);
        move_valid = 1'b1; step(); move_valid = 1'b0;
        check("move2", 4'd0, 4'd3, 4'd3, 4'd3, 1'b0, 1'b1);
        move_valid = 1'b1; step(); move_valid = 1'b0;
        check("move3", 4'd1, 4'd3, 4'd3, 4'd3, 1'b1, 1'b1);

        // Win with coincident move: no toggle, 16-cycle blink then IDLE
        game_win = 1'b1; move_valid = 1'b1; step(); game_win = 1'b0; move_valid = 1'b0;
        check("win_c0", 4'd1, 4'd4, 4'd5, 4'd6, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) begin
            step();
            if (((i / 4) % 2) == 0)
                check($sformatf("win_on_c%0d", i), 4'd1, 4'd4, 4'd5, 4'd6, 1'b1, 1'b0);
            else
                check($sformatf("win_off_c%0d", i), 4'd3, 4'd3, 4'd3, 4'd3, 1'b1, 1'b0);
        end
        step();
        check("win_to_idle", 4'd2, 4'd3, 4'd3, 4'd3, 1'b1, 1'b0);

        // Draw, with move_valid held high throughout the blink
        start = 1'b1; step(); start = 1'b0;
        check("play_again", 4'd0, 4'd3, 4'd3, 4'd3, 1'b0, 1'b1);
        game_draw = 1'b1; step(); game_draw = 1'b0;
        check("draw_c0", 4'd3, 4'd2, 4'd2, 4'd2, 1'b0, 1'b0);
        move_valid = 1'b1;
        for (int i = 1; i < 16; i++) begin
            step();
            if (((i / 4) % 2) == 0)
                check($sformatf("draw_on_c%0d", i), 4'd3, 4'd2, 4'd2, 4'd2, 1'b0, 1'b0);
            else
                check($sformatf("draw_off_c%0d", i), 4'd3, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0);
        end
        step();
        move_valid = 1'b0;
        check("draw_to_idle", 4'd2, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0);

        // start beats game_win in PLAY
        start = 1'b1; step();
        check("start_p0", 4'd0, 4'd3, 4'd3, 4'd3, 1'b0, 1'b1);
        move_valid = 1'b1; step(); move_valid = 1'b0;
        game_win = 1'b1; step(); start = 1'b0; game_win = 1'b0;
        check("start_over_win", 4'd0, 4'd3, 4'd3, 4'd3, 1'b0, 1'b1);

        // start during WIN OFF phase, then fresh win blinks a full ON phase
        move_valid = 1'b1; step(); move_valid = 1'b0;
        game_win = 1'b1; step(); game_win = 1'b0;
        check("win2_c0", 4'd1, 4'd4, 4'd5, 4'd6, 1'b1, 1'b0);
        step(); step(); step(); step();
        check("win2_off_c4", 4'd3, 4'd3, 4'd3, 4'd3, 1'b1, 1'b0);
        step();
        check("win2_off_c5", 4'd3, 4'd3, 4'd3, 4'd3, 1'b1, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        check("restart_from_off", 4'd0, 4'd3, 4'd3, 4'd3, 1'b0, 1'b1);
        game_win = 1'b1; step(); game_win = 1'b0;
        check("win3_c0", 4'd0, 4'd4, 4'd5, 4'd6, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            step();
            check($sformatf("win3_on_c%0d", i), 4'd0, 4'd4, 4'd5, 4'd6, 1'b0, 1'b0);
        end
        step();
        check("win3_off_c4", 4'd3, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0);

        // Reset during WIN ON phase
        start = 1'b1; step(); start = 1'b0;
        move_valid = 1'b1; step(); move_valid = 1'b0;
        game_win = 1'b1; step(); game_win = 1'b0;
        step();
        check("win4_on_c1", 4'd1, 4'd4, 4'd5, 4'd6, 1'b1, 1'b0);
        reset = 1'b1; step(); reset = 1'b0;
        check("reset_in_win", 4'd2, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0);

        // Reset during PLAY with player 1
        start = 1'b1; step(); start = 1'b0;
        move_valid = 1'b1; step(); move_valid = 1'b0;
        check("play_p1", 4'd1, 4'd3, 4'd3, 4'd3, 1'b1, 1'b1);
        reset = 1'b1; step(); reset = 1'b0;
        check("reset_in_play", 4'd2, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        check("start_after_reset", 4'd0, 4'd3, 4'd3, 4'd3, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
